// File: rtl/parity_rx.sv
// Serial-to-parallel parity receiver with a one-entry output buffer; PARITY_RX_ERR_COUNT_EN adds err_count.
// Latency: frame appears on out_valid one cycle after its parity bit. Backpressure: a full, unaccepted buffer drops new frames and sets overrun.
module parity_rx #(
    parameter int DATA_W = 8,
    parameter int ODD    = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              sin_start,
    input  logic              sin_valid,
    input  logic              sin_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err,
    output logic              overrun
`ifdef PARITY_RX_ERR_COUNT_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam logic ODD_BIT = (ODD != 0);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] shift_q, shift_nxt;
    logic [5:0]        cnt_q, cnt_nxt;
    logic              par_q, par_nxt;
    logic              done;
    logic              done_err;
    logic              load;
    logic              drop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            cnt_q   <= cnt_nxt;
            par_q   <= par_nxt;
        end
    end

    // A start bit restarts the frame from any state, so it is handled ahead of the per-state logic.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        par_nxt   = par_q;
        done      = 1'b0;
        done_err  = par_q ^ sin_bit ^ ODD_BIT;
        if (sin_valid) begin
            if (sin_start) begin
                shift_nxt    = '0;
                shift_nxt[0] = sin_bit;
                cnt_nxt      = 6'd1;
                par_nxt      = sin_bit;
                state_nxt    = DATA;
            end else begin
                case (state)
                    IDLE: begin
                    end
                    DATA: begin
                        for (int i = 0; i < DATA_W; i++) begin
                            if (cnt_q == 6'(i)) shift_nxt[i] = sin_bit;
                        end
                        par_nxt = par_q ^ sin_bit;
                        cnt_nxt = cnt_q + 6'd1;
                        if (cnt_q == 6'(DATA_W - 1)) state_nxt = PARITY;
                    end
                    PARITY: begin
                        done      = 1'b1;
                        cnt_nxt   = 6'd0;
                        par_nxt   = 1'b0;
                        state_nxt = IDLE;
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    assign load = done && (!out_valid || out_ready);
    assign drop = done && out_valid && !out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= shift_q;
                out_err   <= done_err;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop) overrun <= 1'b1;
        end
    end

`ifdef PARITY_RX_ERR_COUNT_EN
    // Only frames that reach the buffer are counted; dropped frames are reported via overrun.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_count <= 8'd0;
        end else if (load && done_err && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_parity_rx.sv
// Directed bench for parity_rx: an 8-bit even-parity instance and a 4-bit odd-parity instance.
module tb_parity_rx;

    logic       clock;
    logic       reset;
    logic       sin_start;
    logic       sin_valid;
    logic       sin_bit;
    logic       sel;
    logic       out_ready;
    logic       v8, v4;

    logic       o8_valid, o8_err, o8_ovr;
    logic [7:0] o8_data;
    logic       o4_valid, o4_err, o4_ovr;
    logic [3:0] o4_data;
`ifdef PARITY_RX_ERR_COUNT_EN
    logic [7:0] o8_cnt, o4_cnt;
`endif

    int pass_cnt = 0;
    int chk_cnt  = 0;

    assign v8 = sin_valid && !sel;
    assign v4 = sin_valid && sel;

    parity_rx #(.DATA_W(8), .ODD(0)) dut8 (
        .clock     (clock),
        .reset     (reset),
        .sin_start (sin_start),
        .sin_valid (v8),
        .sin_bit   (sin_bit),
        .out_valid (o8_valid),
        .out_ready (out_ready),
        .out_data  (o8_data),
        .out_err   (o8_err),
        .overrun   (o8_ovr)
`ifdef PARITY_RX_ERR_COUNT_EN
        ,
        .err_count (o8_cnt)
`endif
    );

    parity_rx #(.DATA_W(4), .ODD(1)) dut4 (
        .clock     (clock),
        .reset     (reset),
        .sin_start (sin_start),
        .sin_valid (v4),
        .sin_bit   (sin_bit),
        .out_valid (o4_valid),
        .out_ready (out_ready),
        .out_data  (o4_data),
        .out_err   (o4_err),
        .overrun   (o4_ovr)
`ifdef PARITY_RX_ERR_COUNT_EN
        ,
        .err_count (o4_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bit(input logic st, input logic b);
        sin_valid = 1'b1;
        sin_start = st;
        sin_bit   = b;
        @(posedge clock);
        #1;
        sin_valid = 1'b0;
        sin_start = 1'b0;
    endtask

    // Start bit + n-1 data bits + parity bit, optional idle gap after each bit.
    task automatic send_frame(input logic [31:0] d, input int n, input logic p, input int gap);
        send_bit(1'b1, d[0]);
        idle(gap);
        for (int i = 1; i < n; i++) begin
            send_bit(1'b0, d[i]);
            idle(gap);
        end
        send_bit(1'b0, p);
    endtask

    initial begin
        reset     = 1'b1;
        sin_start = 1'b0;
        sin_valid = 1'b0;
        sin_bit   = 1'b0;
        sel       = 1'b0;
        out_ready = 1'b1;
        idle(2);
        check("rst_valid", o8_valid, 0);
        check("rst_data", o8_data, 0);
        check("rst_err", o8_err, 0);
        check("rst_ovr", o8_ovr, 0);
        check("rst_valid4", o4_valid, 0);
`ifdef PARITY_RX_ERR_COUNT_EN
        check("rst_cnt", o8_cnt, 0);
`endif
        reset = 1'b0;
        idle(1);

        // 0xA5 has four ones: even parity bit 0 is correct
        send_frame(32'hA5, 8, 1'b0, 0);
        check("a5_valid", o8_valid, 1);
        check("a5_data", o8_data, 8'hA5);
        check("a5_err", o8_err, 0);
        idle(1);
        check("a5_pulse", o8_valid, 0);

        send_frame(32'h01, 8, 1'b0, 0);
        check("01_valid", o8_valid, 1);
        check("01_data", o8_data, 8'h01);
        check("01_err", o8_err, 1);
`ifdef PARITY_RX_ERR_COUNT_EN
        check("01_cnt", o8_cnt, 1);
`endif
        idle(1);

        // Full buffer with no ready: second frame is dropped
        out_ready = 1'b0;
        send_frame(32'h3C, 8, 1'b0, 0);
        check("3c_valid", o8_valid, 1);
        check("3c_data", o8_data, 8'h3C);
        check("3c_ovr", o8_ovr, 0);
        send_frame(32'hFF, 8, 1'b0, 0);
        check("ff_keep_data", o8_data, 8'h3C);
        check("ff_keep_valid", o8_valid, 1);
        check("ff_ovr", o8_ovr, 1);
        out_ready = 1'b1;
        idle(1);
        check("ovr_hs_valid", o8_valid, 0);
        check("ovr_sticky", o8_ovr, 1);

        // Abort after 4 bits, then a full 0x5A frame
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b1);
        send_bit(1'b0, 1'b1);
        check("abort_noout", o8_valid, 0);
        send_frame(32'h5A, 8, 1'b0, 0);
        check("5a_valid", o8_valid, 1);
        check("5a_data", o8_data, 8'h5A);
        check("5a_err", o8_err, 0);
        idle(1);
        check("5a_once", o8_valid, 0);

        // Back-to-back frames, no gap cycle
        send_frame(32'h12, 8, 1'b0, 0);
        check("b2b1_valid", o8_valid, 1);
        check("b2b1_data", o8_data, 8'h12);
        send_frame(32'h81, 8, 1'b1, 0);
        check("b2b2_valid", o8_valid, 1);
        check("b2b2_data", o8_data, 8'h81);
        check("b2b2_err", o8_err, 1);
        idle(1);

        // Idle cycles between bits must not disturb the frame
        send_frame(32'h96, 8, 1'b0, 2);
        check("gap_valid", o8_valid, 1);
        check("gap_data", o8_data, 8'h96);
        check("gap_err", o8_err, 0);
`ifdef PARITY_RX_ERR_COUNT_EN
        check("cnt_two", o8_cnt, 2);
`endif
        idle(1);

        // Reset mid-frame with a buffered erroneous frame and overrun set
        out_ready = 1'b0;
        send_frame(32'h77, 8, 1'b1, 0);
        check("77_err", o8_err, 1);
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b1);
        reset = 1'b1;
        #1;
        check("mrst_valid", o8_valid, 0);
        check("mrst_data", o8_data, 0);
        check("mrst_err", o8_err, 0);
        check("mrst_ovr", o8_ovr, 0);
`ifdef PARITY_RX_ERR_COUNT_EN
        check("mrst_cnt", o8_cnt, 0);
`endif
        idle(1);
        reset     = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send_bit(1'b0, 1'b1);
            check("nostart_noout", o8_valid, 0);
        end
        send_frame(32'hC3, 8, 1'b0, 0);
        check("post_rst_data", o8_data, 8'hC3);
        check("post_rst_valid", o8_valid, 1);
        idle(1);

        // Odd parity, 4-bit: 0x7 has three ones
        sel = 1'b1;
        send_frame(32'h7, 4, 1'b0, 0);
        check("odd_ok_valid", o4_valid, 1);
        check("odd_ok_data", o4_data, 4'h7);
        check("odd_ok_err", o4_err, 0);
        send_frame(32'h7, 4, 1'b1, 0);
        check("odd_bad_valid", o4_valid, 1);
        check("odd_bad_err", o4_err, 1);
        check("odd_8_quiet", o8_valid, 0);
`ifdef PARITY_RX_ERR_COUNT_EN
        check("odd_cnt1", o4_cnt, 1);
        for (int i = 0; i < 300; i++) send_frame(32'h7, 4, 1'b1, 0);
        check("cnt_sat", o4_cnt, 255);
`endif
        sel = 1'b0;
        idle(2);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
